tow_match_controller: RTL and testbench

Match sequencer for the player-vs-computer tug-of-war light chain. It edge-detects the two press inputs (human and computer), arbitrates simultaneous presses, and drives single-cycle L/R pulses into the light chain. It detects a point when an end light is lit and its side presses, restarts the chain for each round, and keeps saturating scores until one side reaches the match target.

---
 rtl/tow_match_controller.sv | 163 ++++++++++++++++
 tb/tb_tow_match_controller.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tow_match_controller.sv
// Match sequencer for the tug-of-war light chain: press edge detect, arbitration, move pulses, scoring.
// Latency: a press edge in PLAY yields a move pulse one cycle later; a point updates the score two cycles after the edge.
// Backpressure: none; pulses are fire-and-forget, presses outside PLAY are dropped and new_game only acts in GAME_OVER.
module tow_match_controller #(
  parameter int NUM_LIGHTS = 9,
  parameter int SCORE_W    = 3,
  parameter int WIN_SCORE  = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  press_l,
  input  logic                  press_r,
  input  logic                  new_game,
  input  logic [NUM_LIGHTS-1:0] lights,
  output logic                  l_pulse,
  output logic                  r_pulse,
  output logic                  round_reset,
  output logic [SCORE_W-1:0]    score_l,
  output logic [SCORE_W-1:0]    score_r,
  output logic                  game_over,
  output logic                  winner
);

  localparam logic [2:0] ST_ROUND_INIT = 3'd0;
  localparam logic [2:0] ST_PLAY       = 3'd1;
  localparam logic [2:0] ST_POINT_L    = 3'd2;
  localparam logic [2:0] ST_POINT_R    = 3'd3;
  localparam logic [2:0] ST_GAME_OVER  = 3'd4;

  localparam logic [SCORE_W-1:0]    SCORE_MAX = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0]    SCORE_WIN = SCORE_W'(WIN_SCORE);
  // Masks selecting the two end lights; leftmost light is the MSB.
  localparam logic [NUM_LIGHTS-1:0] LEFT_END  = NUM_LIGHTS'(1) << (NUM_LIGHTS - 1);
  localparam logic [NUM_LIGHTS-1:0] RIGHT_END = NUM_LIGHTS'(1);

  logic [2:0]         state_q, state_d;
  logic               l_pulse_q, l_pulse_d;
  logic               r_pulse_q, r_pulse_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d;
  logic [SCORE_W-1:0] score_r_q, score_r_d;
  logic               winner_q, winner_d;
  logic               prev_l_q, prev_l_d;
  logic               prev_r_q, prev_r_d;
  logic               prev_ng_q, prev_ng_d;

  logic               l_edge, r_edge, ng_edge;
  logic               left_end_lit, right_end_lit;
  logic [SCORE_W-1:0] score_l_inc, score_r_inc;

  // Rising-edge detection; the previous-value registers track every cycle so a held level never re-fires.
  always_comb begin
    prev_l_d  = press_l;
    prev_r_d  = press_r;
    prev_ng_d = new_game;
    l_edge    = press_l  & ~prev_l_q;
    r_edge    = press_r  & ~prev_r_q;
    ng_edge   = new_game & ~prev_ng_q;
  end

  // End-light status and saturating score increments used by the point states.
  always_comb begin
    left_end_lit  = |(lights & LEFT_END);
    right_end_lit = |(lights & RIGHT_END);
    score_l_inc   = (score_l_q == SCORE_MAX) ? score_l_q : score_l_q + SCORE_W'(1);
    score_r_inc   = (score_r_q == SCORE_MAX) ? score_r_q : score_r_q + SCORE_W'(1);
  end

  // Match sequencing: round restart, play arbitration, point scoring and game-over hold.
  always_comb begin
    state_d   = state_q;
    l_pulse_d = 1'b0;
    r_pulse_d = 1'b0;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    winner_d  = winner_q;
    case (state_q)
      ST_ROUND_INIT: begin
        state_d = ST_PLAY;
      end
      ST_PLAY: begin
        // Simultaneous edges cancel each other out.
        if (l_edge && !r_edge) begin
          if (left_end_lit) begin
            state_d = ST_POINT_L;
          end else begin
            l_pulse_d = 1'b1;
          end
        end else if (r_edge && !l_edge) begin
          if (right_end_lit) begin
            state_d = ST_POINT_R;
          end else begin
            r_pulse_d = 1'b1;
          end
        end
      end
      ST_POINT_L: begin
        score_l_d = score_l_inc;
        if (score_l_inc == SCORE_WIN) begin
          state_d  = ST_GAME_OVER;
          winner_d = 1'b1;
        end else begin
          state_d = ST_ROUND_INIT;
        end
      end
      ST_POINT_R: begin
        score_r_d = score_r_inc;
        if (score_r_inc == SCORE_WIN) begin
          state_d  = ST_GAME_OVER;
          winner_d = 1'b0;
        end else begin
          state_d = ST_ROUND_INIT;
        end
      end
      ST_GAME_OVER: begin
        if (ng_edge) begin
          score_l_d = '0;
          score_r_d = '0;
          state_d   = ST_ROUND_INIT;
        end
      end
      default: begin
        state_d = ST_ROUND_INIT;
      end
    endcase
  end

  // State registers; reset drops any pending pulse or score update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_ROUND_INIT;
      l_pulse_q <= 1'b0;
      r_pulse_q <= 1'b0;
      score_l_q <= '0;
      score_r_q <= '0;
      winner_q  <= 1'b0;
      prev_l_q  <= 1'b0;
      prev_r_q  <= 1'b0;
      prev_ng_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      l_pulse_q <= l_pulse_d;
      r_pulse_q <= r_pulse_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      winner_q  <= winner_d;
      prev_l_q  <= prev_l_d;
      prev_r_q  <= prev_r_d;
      prev_ng_q <= prev_ng_d;
    end
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    l_pulse     = l_pulse_q;
    r_pulse     = r_pulse_q;
    round_reset = (state_q == ST_ROUND_INIT);
    game_over   = (state_q == ST_GAME_OVER);
    score_l     = score_l_q;
    score_r     = score_r_q;
    winner      = winner_q;
  end

endmodule

// File: tb/tb_tow_match_controller.sv
// Bench for the tug-of-war match sequencer.
// Move pulses are scoreboarded: expected pulses are queued when a press is driven and matched on arrival.
// Scores, round_reset and game-over state are checked inline by each scenario task.
module tb_tow_match_controller;

  localparam int NL = 9;
  localparam int SW = 3;
  localparam int WS = 7;

  logic          clk      = 1'b0;
  logic          reset    = 1'b0;
  logic          press_l  = 1'b0;
  logic          press_r  = 1'b0;
  logic          new_game = 1'b0;
  logic [NL-1:0] lights   = 9'b000010000;
  logic          l_pulse, r_pulse, round_reset, game_over, winner;
  logic [SW-1:0] score_l, score_r;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct packed {
    logic        l;
    logic        r;
    logic [31:0] cyc;
  } exp_t;

  exp_t exp_q[$];

  tow_match_controller #(.NUM_LIGHTS(NL), .SCORE_W(SW), .WIN_SCORE(WS)) dut (
    .clk         (clk),
    .reset       (reset),
    .press_l     (press_l),
    .press_r     (press_r),
    .new_game    (new_game),
    .lights      (lights),
    .l_pulse     (l_pulse),
    .r_pulse     (r_pulse),
    .round_reset (round_reset),
    .score_l     (score_l),
    .score_r     (score_r),
    .game_over   (game_over),
    .winner      (winner)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: every pulse must match the head of the expected queue, in kind and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].cyc < 32'(cyc)) begin
      e = exp_q.pop_front();
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL missing_pulse got none at cyc %0d, required l=%b r=%b at cyc %0d", cyc, e.l, e.r, e.cyc);
    end
    if (l_pulse !== 1'b0 || r_pulse !== 1'b0) begin
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_pulse got l=%b r=%b at cyc %0d, required no pulse", l_pulse, r_pulse, cyc);
      end else begin
        e = exp_q.pop_front();
        if ({l_pulse, r_pulse} !== {e.l, e.r} || 32'(cyc) !== e.cyc) begin
          errors = errors + 1;
          $display("FAIL pulse_match got l=%b r=%b at cyc %0d, required l=%b r=%b at cyc %0d",
                   l_pulse, r_pulse, cyc, e.l, e.r, e.cyc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pulse(input logic l, input logic r);
    exp_t e;
    e.l   = l;
    e.r   = r;
    e.cyc = 32'(cyc + 1);
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    lights = 9'b000010000;
    repeat (3) step();
    checks = checks + 1;
    if (round_reset !== 1'b1) begin errors = errors + 1; $display("FAIL rst_round_reset got %b required 1", round_reset); end
    checks = checks + 1;
    if ({l_pulse, r_pulse} !== 2'b00) begin errors = errors + 1; $display("FAIL rst_pulses got %b%b required 00", l_pulse, r_pulse); end
    checks = checks + 1;
    if (score_l !== 3'd0 || score_r !== 3'd0) begin errors = errors + 1; $display("FAIL rst_scores got %0d/%0d required 0/0", score_l, score_r); end
    checks = checks + 1;
    if (game_over !== 1'b0 || winner !== 1'b0) begin errors = errors + 1; $display("FAIL rst_game got go=%b w=%b required 0 0", game_over, winner); end
    reset = 1'b1;
    #1;
    checks = checks + 1;
    if (round_reset !== 1'b1) begin errors = errors + 1; $display("FAIL release_round_reset got %b required 1", round_reset); end
    step();
    checks = checks + 1;
    if (round_reset !== 1'b0) begin errors = errors + 1; $display("FAIL play_round_reset got %b required 0", round_reset); end
  endtask

  task automatic test_pulses();
    press_r = 1'b1;
    expect_pulse(1'b0, 1'b1);
    step();
    checks = checks + 1;
    if (r_pulse !== 1'b1) begin errors = errors + 1; $display("FAIL r_pulse_hi got %b required 1", r_pulse); end
    step();
    checks = checks + 1;
    if (r_pulse !== 1'b0) begin errors = errors + 1; $display("FAIL r_pulse_len got %b required 0", r_pulse); end
    repeat (3) step();
    press_r = 1'b0;
    step();
    press_l = 1'b1;
    expect_pulse(1'b1, 1'b0);
    step();
    checks = checks + 1;
    if (l_pulse !== 1'b1) begin errors = errors + 1; $display("FAIL l_pulse_hi got %b required 1", l_pulse); end
    step();
    press_l = 1'b0;
    step();
  endtask

  task automatic test_simultaneous();
    press_l = 1'b1;
    press_r = 1'b1;
    step();
    checks = checks + 1;
    if ({l_pulse, r_pulse} !== 2'b00) begin errors = errors + 1; $display("FAIL simul_pulses got %b%b required 00", l_pulse, r_pulse); end
    step();
    checks = checks + 1;
    if (round_reset !== 1'b0 || score_l !== 3'd0 || score_r !== 3'd0) begin
      errors = errors + 1;
      $display("FAIL simul_no_point got rr=%b %0d/%0d required 0 0/0", round_reset, score_l, score_r);
    end
    press_l = 1'b0;
    press_r = 1'b0;
    step();
  endtask

  task automatic test_point_l();
    lights = 9'b100000000;
    press_l = 1'b1;
    step();
    checks = checks + 1;
    if (l_pulse !== 1'b0 || score_l !== 3'd0) begin errors = errors + 1; $display("FAIL point_l_edge got p=%b s=%0d required 0 0", l_pulse, score_l); end
    step();
    checks = checks + 1;
    if (score_l !== 3'd1 || round_reset !== 1'b1) begin errors = errors + 1; $display("FAIL point_l_score got s=%0d rr=%b required 1 1", score_l, round_reset); end
    step();
    checks = checks + 1;
    if (round_reset !== 1'b0) begin errors = errors + 1; $display("FAIL point_l_play got rr=%b required 0", round_reset); end
    press_l = 1'b0;
    step();
  endtask

  task automatic test_win_r();
    lights = 9'b000000001;
    for (int i = 1; i <= WS; i++) begin
      press_r = 1'b1;
      step();
      step();
      checks = checks + 1;
      if (score_r !== SW'(i)) begin errors = errors + 1; $display("FAIL win_r_score got %0d required %0d", score_r, i); end
      checks = checks + 1;
      if (game_over !== (i == WS)) begin errors = errors + 1; $display("FAIL win_r_go got %b required %b at point %0d", game_over, (i == WS), i); end
      press_r = 1'b0;
      step();
    end
    checks = checks + 1;
    if (winner !== 1'b0) begin errors = errors + 1; $display("FAIL win_r_winner got %b required 0", winner); end
    for (int k = 0; k < 3; k++) begin
      press_r = 1'b1; step();
      press_r = 1'b0; step();
      press_l = 1'b1; step();
      press_l = 1'b0; step();
    end
    checks = checks + 1;
    if (score_r !== 3'd7 || score_l !== 3'd1 || game_over !== 1'b1 || winner !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL game_over_hold got %0d/%0d go=%b w=%b required 1/7 go=1 w=0", score_l, score_r, game_over, winner);
    end
  endtask

  task automatic test_new_game();
    lights = 9'b000010000;
    new_game = 1'b1;
    step();
    checks = checks + 1;
    if (score_l !== 3'd0 || score_r !== 3'd0 || round_reset !== 1'b1 || game_over !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL new_game got %0d/%0d rr=%b go=%b required 0/0 rr=1 go=0", score_l, score_r, round_reset, game_over);
    end
    step();
    checks = checks + 1;
    if (round_reset !== 1'b0) begin errors = errors + 1; $display("FAIL ng_play got rr=%b required 0", round_reset); end
    repeat (4) step();
    new_game = 1'b0;
    step();
    new_game = 1'b1;
    step();
    step();
    checks = checks + 1;
    if (round_reset !== 1'b0 || game_over !== 1'b0) begin errors = errors + 1; $display("FAIL ng_in_play got rr=%b go=%b required 0 0", round_reset, game_over); end
    press_r = 1'b1;
    expect_pulse(1'b0, 1'b1);
    step();
    step();
    press_r = 1'b0;
    new_game = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_point();
    lights = 9'b100000000;
    press_l = 1'b1;
    step();
    step();
    checks = checks + 1;
    if (score_l !== 3'd1) begin errors = errors + 1; $display("FAIL mid_setup got %0d required 1", score_l); end
    press_l = 1'b0;
    step();
    press_l = 1'b1;
    step();
    reset = 1'b0;
    #1;
    checks = checks + 1;
    if (score_l !== 3'd0 || round_reset !== 1'b1 || {l_pulse, r_pulse} !== 2'b00) begin
      errors = errors + 1;
      $display("FAIL async_reset got s=%0d rr=%b p=%b%b required 0 1 00", score_l, round_reset, l_pulse, r_pulse);
    end
    step();
    step();
    checks = checks + 1;
    if (score_l !== 3'd0) begin errors = errors + 1; $display("FAIL reset_lost_point got %0d required 0", score_l); end
    press_l = 1'b0;
    lights = 9'b000010000;
    reset = 1'b1;
    step();
    press_r = 1'b1;
    #1;
    reset = 1'b0;
    step();
    checks = checks + 1;
    if (r_pulse !== 1'b0) begin errors = errors + 1; $display("FAIL reset_lost_pulse got %b required 0", r_pulse); end
    press_r = 1'b0;
    reset = 1'b1;
    repeat (3) step();
  endtask

  initial begin
    test_reset();
    test_pulses();
    test_simultaneous();
    test_point_l();
    test_win_r();
    test_new_game();
    test_reset_mid_point();
    checks = checks + 1;
    if (exp_q.size() != 0) begin errors = errors + 1; $display("FAIL pending_pulses got %0d outstanding required 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
